// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin scheduler sharing one combinational multiplier
// Two register stages: S1 drives the multiplier operands, S2 captures the product for the response port.
module mult_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int W       = 16,
    parameter int IDW     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ*W-1:0] req_x_i,
    input  logic [NUM_REQ*W-1:0] req_y_i,
    output logic [W-1:0]         mult_x_o,
    output logic [W-1:0]         mult_y_o,
    input  logic [2*W-1:0]       mult_p_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [2*W-1:0]       rsp_p_o,
    output logic                 busy_o
);

    logic               s1_v_q, s1_v_d;
    logic [IDW-1:0]     s1_id_q, s1_id_d;
    logic [W-1:0]       mult_x_q, mult_x_d;
    logic [W-1:0]       mult_y_q, mult_y_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [2*W-1:0]     rsp_p_q, rsp_p_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

    logic               s1_en;
    logic               s2_en;
    logic               gnt_any;
    logic [IDW-1:0]     gnt_id;
    logic [NUM_REQ-1:0] grant;

    assign s2_en = !rsp_valid_q || rsp_ready_i;
    assign s1_en = !s1_v_q || s2_en;

    // Ready is derived only from local pipeline state, never from another requester's ready.
    always_comb begin : arbiter
        logic [IDW-1:0] idx;
        idx     = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        grant   = '0;
        if (s1_en && !rst_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!gnt_any && req_valid_i[idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = idx;
                end
            end
        end
        if (gnt_any) begin
            grant = NUM_REQ'(1) << gnt_id;
        end
    end

    always_comb begin : next_state
        s1_v_d      = s1_v_q;
        s1_id_d     = s1_id_q;
        mult_x_d    = mult_x_q;
        mult_y_d    = mult_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;
        rr_ptr_d    = rr_ptr_q;
        if (s2_en) begin
            rsp_valid_d = s1_v_q;
            if (s1_v_q) begin
                rsp_p_d  = mult_p_i;
                rsp_id_d = s1_id_q;
            end
        end
        if (s1_en) begin
            s1_v_d = gnt_any;
            if (gnt_any) begin
                mult_x_d = req_x_i[int'(gnt_id)*W +: W];
                mult_y_d = req_y_i[int'(gnt_id)*W +: W];
                s1_id_d  = gnt_id;
                rr_ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q      <= 1'b0;
            s1_id_q     <= '0;
            mult_x_q    <= '0;
            mult_y_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
            rr_ptr_q    <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_id_q     <= s1_id_d;
            mult_x_q    <= mult_x_d;
            mult_y_q    <= mult_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign req_ready_o = grant;
    assign mult_x_o    = mult_x_q;
    assign mult_y_o    = mult_y_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_p_o     = rsp_p_q;
    assign busy_o      = s1_v_q || rsp_valid_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - self-checking bench for mult_rr_scheduler
// The shared multiplier is modelled here as an exact combinational product.
module tb_mult_rr_scheduler;
    localparam int NUM_REQ = 4;
    localparam int W       = 16;
    localparam int IDW     = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_x = '0;
    logic [NUM_REQ*W-1:0] req_y = '0;
    logic [W-1:0]         mult_x, mult_y;
    logic [2*W-1:0]       mult_p;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [IDW-1:0]       rsp_id;
    logic [2*W-1:0]       rsp_p;
    logic                 busy;

    mult_rr_scheduler #(.NUM_REQ(NUM_REQ), .W(W), .IDW(IDW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_x_i(req_x), .req_y_i(req_y),
        .mult_x_o(mult_x), .mult_y_o(mult_y), .mult_p_i(mult_p),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_p_o(rsp_p), .busy_o(busy)
    );

    always #5 clk = ~clk;
    assign mult_p = 32'(mult_x) * 32'(mult_y);

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; logic [2*W-1:0] p; int acc; } exp_t;
    exp_t q[$];
    int   m_ptr = 0;
    int   waits [NUM_REQ];
    logic stall_prev = 1'b0;
    logic [2*W-1:0] prev_p;
    logic [IDW-1:0] prev_id;

    // Scoreboard monitor: predicts grants, pushes expected products, pops on response handshakes.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_ptr = 0;
            stall_prev = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
        end else begin
            logic exp_s1, exp_en;
            logic [NUM_REQ-1:0] exp_vec;
            int w, idx;
            if (stall_prev) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_p", rsp_p, prev_p);
                chk("hold_id", rsp_id, prev_id);
            end
            if (!rsp_valid && q.size() > 0) chk("latency", q[0].acc, cyc);
            exp_s1 = q.size() > (rsp_valid ? 1 : 0);
            exp_en = !exp_s1 || !rsp_valid || rsp_ready;
            exp_vec = '0;
            w = -1;
            if (exp_en) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
            end
            if (w >= 0) exp_vec[w] = 1'b1;
            chk("req_ready", req_ready, exp_vec);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) waits[i] = 0;
                else if (req_valid[i] && req_ready != '0) begin
                    waits[i]++;
                    chk("starve", waits[i] < NUM_REQ, 1);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_pops++;
                if (q.size() == 0) chk("rsp_spurious", 1, 0);
                else begin
                    chk("rsp_id", rsp_id, q[0].id);
                    chk("rsp_p", rsp_p, q[0].p);
                    void'(q.pop_front());
                end
            end
            if (w >= 0) begin
                q.push_back('{w, 32'(req_x[w*W +: W]) * 32'(req_y[w*W +: W]), cyc + 1});
                m_ptr = (w + 1) % NUM_REQ;
            end
            stall_prev = rsp_valid && !rsp_ready;
            prev_p  = rsp_p;
            prev_id = rsp_id;
        end
    end

    typedef struct { int id; logic [W-1:0] x; logic [W-1:0] y; logic [2*W-1:0] p; } vec_t;
    vec_t tbl [7];

    task automatic run_op(input vec_t r);
        logic ok;
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[r.id] = 1'b1;
        req_x[r.id*W +: W] = r.x;
        req_y[r.id*W +: W] = r.y;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[r.id]) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("op_accept", ok, 1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("op_not_early", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("op_valid", rsp_valid, 1);
        chk("op_id", rsp_id, r.id);
        chk("op_p", rsp_p, r.p);
    endtask

    task automatic wait_idle(input string name);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        int cnt, pops0;
        logic [NUM_REQ-1:0] acc;
        tbl[0] = '{0, 16'd3,    16'd5,    32'd15};
        tbl[1] = '{1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        tbl[2] = '{2, 16'h0000, 16'h1234, 32'h0};
        tbl[3] = '{3, 16'h8000, 16'h0002, 32'h00010000};
        tbl[4] = '{3, 16'h0001, 16'hFFFF, 32'h0000FFFF};
        tbl[5] = '{1, 16'h00FF, 16'h0100, 32'h0000FF00};
        tbl[6] = '{2, 16'd7,    16'd9,    32'd63};

        // Reset with every requester asking
        req_valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_x[i*W +: W] = W'(i + 2);
            req_y[i*W +: W] = W'(i + 10);
        end

        // Fairness from rr_ptr=0, one grant every cycle
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("fair_gnt", req_ready, NUM_REQ'(1) << (c % NUM_REQ));
            @(posedge clk); #1;
        end
        req_valid = '0;
        wait_idle("fair_drain");

        for (int i = 0; i < 6; i++) run_op(tbl[i]);
        wait_idle("tbl_drain");

        // Back-pressure: only two ops fit before the stall
        @(posedge clk); #1;
        req_valid = '1;
        rsp_ready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) cnt++;
            @(posedge clk);
        end
        chk("bp_accepts", cnt, 2);
        #1;
        pops0 = n_pops;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("bp_drain");
        chk("bp_returns", n_pops - pops0, 2);

        // Reset with one op in S1 and one stalled in S2
        @(posedge clk); #1;
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy_clr", busy, 0);
        run_op(tbl[6]);
        wait_idle("mid_drain");

        // Random traffic; requesters hold operands until accepted
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_x[i*W +: W] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                    req_y[i*W +: W] = W'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("rand_drain");
        @(negedge clk);
        chk("rand_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
